// File: rtl/ioctl_pkg.sv
// Shared types and widths for the ioctl download sequencer.
package ioctl_pkg;

  localparam int IOCTL_ADDR_W = 25;
  localparam int BYTE_W       = 8;
  localparam int INDEX_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/dn_byte_fifo.sv
// Plain synchronous FIFO; the caller decides when push/pop are legal.
module dn_byte_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 22,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_sys) begin
    if (i_push) r_mem[r_wptr] <= i_wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/ioctl_dn_sequencer.sv
// Buffers MiSTer ioctl download bytes into the core's write port and owns
// the core reset (held during download, stretched after the last write).
//
//   state | meaning
//   IDLE  | core running, sys_reset low
//   LOAD  | download window open, bytes accepted and drained
//   DRAIN | window closed, emptying the FIFO
//   HOLD  | FIFO empty, counting down the reset stretch
module ioctl_dn_sequencer
  import ioctl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 14,
  parameter int RESET_HOLD = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [BYTE_W-1:0]       ioctl_dout,
  input  logic [INDEX_W-1:0]      ioctl_index,
  output logic                    ioctl_wait,
  output logic [ADDR_W-1:0]       dn_addr,
  output logic [BYTE_W-1:0]       dn_data,
  output logic [INDEX_W-1:0]      dn_index,
  output logic                    dn_wr,
  input  logic                    dn_ready,
  output logic                    sys_reset,
  output logic                    err_drop
);

  localparam int FIFO_W = ADDR_W + BYTE_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_ioctl_wait;
  logic                r_dn_wr;
  logic [ADDR_W-1:0]   r_dn_addr;
  logic [BYTE_W-1:0]   r_dn_data;
  logic [INDEX_W-1:0]  r_dn_index;
  logic                r_sys_reset;
  logic                r_err_drop;

  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_start;
  logic                w_addr_ok;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [FIFO_W-1:0]   w_rd_data;

  assign w_addr_ok   = (ioctl_addr[IOCTL_ADDR_W-1:ADDR_W] == '0);
  assign w_pop       = ((r_state == LOAD) || (r_state == DRAIN)) && !w_empty && dn_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
  assign w_push      = (r_state == LOAD) && ioctl_wr && w_addr_ok && (!w_full || w_pop);
  assign w_drop      = (r_state == LOAD) && ioctl_wr && !w_push;
  assign w_start     = ioctl_download && (r_state != LOAD);
  assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  dn_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .i_push    (w_push),
    .i_wr_data ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // A popped entry lands directly in the dn_* registers, so an empty FIFO
  // means nothing is left to emit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ioctl_download) w_state_nxt = LOAD;
      LOAD:    if (!ioctl_download) w_state_nxt = DRAIN;
      DRAIN:   if (ioctl_download) w_state_nxt = LOAD;
               else if (w_empty) w_state_nxt = HOLD;
      HOLD:    if (ioctl_download) w_state_nxt = LOAD;
               else if (r_hold_cnt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= HOLD;
      r_hold_cnt   <= HOLD_INIT;
      r_ioctl_wait <= 1'b0;
      r_dn_wr      <= 1'b0;
      r_dn_addr    <= '0;
      r_dn_data    <= '0;
      r_dn_index   <= '0;
      r_sys_reset  <= 1'b1;
      r_err_drop   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sys_reset  <= (w_state_nxt != IDLE);
      r_ioctl_wait <= (w_count_nxt >= CNT_W'(FIFO_DEPTH - 1));
      r_dn_wr      <= w_pop;
      if (w_pop) {r_dn_addr, r_dn_data} <= w_rd_data;
      if ((r_state == DRAIN) && (w_state_nxt == HOLD)) r_hold_cnt <= HOLD_INIT;
      else if ((r_state == HOLD) && (r_hold_cnt != '0)) r_hold_cnt <= r_hold_cnt - 1'b1;
      if (w_start) begin
        r_dn_index <= ioctl_index;
        r_err_drop <= 1'b0;
      end else if (w_drop) begin
        r_err_drop <= 1'b1;
      end
    end
  end

  assign ioctl_wait = r_ioctl_wait;
  assign dn_wr      = r_dn_wr;
  assign dn_addr    = r_dn_addr;
  assign dn_data    = r_dn_data;
  assign dn_index   = r_dn_index;
  assign sys_reset  = r_sys_reset;
  assign err_drop   = r_err_drop;

endmodule

// File: doc/ioctl_dn_sequencer.md
Name: ioctl_dn_sequencer

Overview:
- Sequences MiSTer ioctl downloads into the system core's download write port (dn_addr/dn_data/dn_wr/dn_index).
- Buffers incoming bytes in a small FIFO and drains them when the target memory signals ready.
- Back-pressures the HPS through ioctl_wait.
- Owns the core reset: held through the download, then stretched by a fixed hold after the last byte lands. Sits between emu top-level ioctl pins and the system instance, replacing a plain OR of reset and ioctl_download.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; power of two, minimum 2.
- ADDR_W, 14, dn_addr width; ioctl_addr bits above this are out of range.
- RESET_HOLD, 16, sys_reset stretch in cycles after the FIFO drains or after reset release; minimum 1.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download window active.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  download target index.
- ioctl_wait  out  1  back-pressure to HPS, registered.
- dn_addr  out  ADDR_W  write address, valid while dn_wr is high.
- dn_data  out  8  write data.
- dn_index  out  8  index latched at download start.
- dn_wr  out  1  one-cycle write pulse.
- dn_ready  in  1  target can accept a write this cycle.
- sys_reset  out  1  reset to the system core.
- err_drop  out  1  sticky: at least one byte was dropped during the current or last download.

Behaviour:
- Reset values: state=HOLD, hold counter=RESET_HOLD-1, FIFO empty, ioctl_wait=0, dn_wr=0, dn_addr=0, dn_data=0, dn_index=0, sys_reset=1, err_drop=0.
- States:
  - IDLE: sys_reset=0.
  - LOAD: sys_reset=1.
  - DRAIN: sys_reset=1.
  - HOLD: sys_reset=1.
- Transitions:
  - IDLE→LOAD when ioctl_download=1. On entry: latch dn_index←ioctl_index, clear err_drop.
  - LOAD→DRAIN when ioctl_download=0.
  - DRAIN→HOLD when the FIFO is empty and no dn_wr is pending. On entry: load counter=RESET_HOLD-1.
  - HOLD→IDLE when the counter reaches 0 (decrements each cycle).
  - In DRAIN or HOLD, ioctl_download=1 forces LOAD (re-latch index, clear err_drop, FIFO contents kept).
- Push:
  - Occurs in LOAD on ioctl_wr=1 when ioctl_addr[24:ADDR_W]==0 and the FIFO is not full.
  - If ioctl_addr[24:ADDR_W]!=0, the byte is discarded and err_drop is set.
  - If the FIFO is full and no pop happens the same cycle, the byte is discarded and err_drop is set.
  - ioctl_wr outside LOAD is ignored and does not set err_drop.
- Pop:
  - Occurs in LOAD or DRAIN when the FIFO is not empty and dn_ready=1.
  - The popped entry is registered into dn_addr/dn_data and dn_wr=1 the following cycle.
  - dn_wr is never high for two consecutive cycles on the same entry.
  - dn_addr/dn_data hold their last values when dn_wr=0.
- Latency: ioctl_wr sampled at edge E0 with empty FIFO and dn_ready=1 gives dn_wr high for the cycle after edge E1, i.e. 2 cycles.
- Simultaneous push and pop: both happen and count is unchanged, including when the FIFO is full.
- ioctl_wait is registered: set to 1 when the next count ≥ FIFO_DEPTH-1, else 0. This leaves one slot for a write already in flight.
- Count arithmetic uses log2(FIFO_DEPTH)+1 bits. Read and write pointers wrap modulo FIFO_DEPTH.
- Reset mid-download: FIFO is flushed, in-flight dn_wr is cancelled (dn_wr=0 next cycle), state returns to HOLD. Bytes pending at reset are lost and do not set err_drop.
- dn_ready low indefinitely: FIFO fills, ioctl_wait stays high, no deadlock, sys_reset stays 1.

Decomposition:
- Shared package ioctl_pkg holds:
  - state enum {IDLE, LOAD, DRAIN, HOLD};
  - localparam IOCTL_ADDR_W=25;
  - byte/index width constants.
- One sub-module: dn_byte_fifo, a synchronous FIFO parameterised on FIFO_DEPTH and data width ADDR_W+8. It has push/pop/full/empty/count ports and no internal policy. The sequencer owns all drop and wait decisions.

Test Plan:
- After reset release, sys_reset stays 1 for exactly 16 cycles then 0; all other outputs hold their reset values.
- Download of 8 bytes with addr 0..7, data 0xA0..0xA7, index 0x01, dn_ready=1, one ioctl_wr every 3 cycles:
  - dn_wr pulses 8 times, each 2 cycles after its ioctl_wr, with matching addr/data and dn_index=0x01;
  - ioctl_wait never rises;
  - sys_reset falls 16 cycles after the last dn_wr.
- dn_ready=0 while 3 back-to-back writes arrive (FIFO_DEPTH=4):
  - ioctl_wait=1 after the 3rd write;
  - a 4th write is accepted, and a 5th while full sets err_drop=1 and is never emitted;
  - after dn_ready=1, exactly 4 dn_wr pulses follow in order.
- Write with ioctl_addr=0x4000 (bit 14 set) → no dn_wr, err_drop=1. A new download start clears err_drop to 0.
- Assert reset with 2 bytes queued → dn_wr=0 the next cycle, the FIFO drains nothing, and sys_reset=1 for 16 cycles after reset release.
- ioctl_download re-asserted during HOLD at counter=5 → state LOAD, sys_reset stays 1 with no glitch, dn_index re-latched to the new index 0x02.
